uart_tx_packet_engine: RTL and testbench

//  Parametrised UART serialiser with an internal baud divider, configurable data width,

---
 rtl/uart_tx_packet_engine_if.sv | 38 +++
 rtl/uart_tx_packet_engine.sv | 207 ++++++++++++++++++++
 tb/tb_uart_tx_packet_engine.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_packet_engine_if.sv
// -----------------------------------------------------------------------------
// uart_tx_packet_engine_if
//   Character handshake between the sample/packet mux and the UART serialiser.
//   The mux drives a character on 'data' with 'valid'. The engine accepts it
//   on any cycle where valid && ready.
//
//   Signals
//     data   DATA_W  character to send (upstream -> engine)
//     valid  1       upstream has a character on data (upstream -> engine)
//     ready  1       engine is idle and will take the character (engine -> upstream)
//
//   Modports
//     master  upstream mux side
//     slave   serialiser side
//
//   DATA_W must match the DATA_W of the engine this interface is connected to.
// -----------------------------------------------------------------------------
interface uart_tx_packet_engine_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/uart_tx_packet_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_packet_engine
//   UART serialiser that has its own baud divider. Data width, parity, stop
//   bits and the idle gap between characters are set by parameters. It also
//   counts which character slot of a fixed-length packet is being sent. The
//   upstream mux uses 'select' to put the matching character on the bus.
//
//   Frame on tx (idle high, LSB first):
//     start(0) | DATA_W data bits | [parity] | STOP_BITS stop(1) | GAP_BITS idle(1)
//   Each bit lasts CLK_DIV clock cycles.
//
//   Ports
//     clk       system clock
//     reset     asynchronous, active-high reset
//     up        character handshake (data / valid / ready), slave side
//     select    packet slot being requested or sent, 0..PACKET_LEN-1
//     tx        serial line, registered
//     busy      a frame is in progress (state is not IDLE)
//     pkt_done  one-cycle pulse when the last slot of a packet completes
//
//   Parameters
//     CLK_DIV (>=2), DATA_W (5..9), PARITY (0 none, 1 even, 2 odd),
//     STOP_BITS (1..2), GAP_BITS (0..3), PACKET_LEN (>=2).
//     SEL_W is derived from PACKET_LEN. Do not override it.
//
//   tx is registered from the current state. It therefore follows the state
//   register by one cycle: tx falls on the clock edge after the handshake edge.
// -----------------------------------------------------------------------------
module uart_tx_packet_engine #(
  parameter int CLK_DIV    = 16,
  parameter int DATA_W     = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int GAP_BITS   = 1,
  parameter int PACKET_LEN = 13,
  parameter int SEL_W      = $clog2(PACKET_LEN)
) (
  input  logic                       clk,
  input  logic                       reset,
  uart_tx_packet_engine_if.slave     up,
  output logic [SEL_W-1:0]           select,
  output logic                       tx,
  output logic                       busy,
  output logic                       pkt_done
);

  // The baud counter has to reach the longest single state, which is either
  // the whole stop period or the whole gap period. The bit counter only has
  // to index the data bits.
  localparam int MAX_MULT = (STOP_BITS > GAP_BITS) ? STOP_BITS : GAP_BITS;
  localparam int BAUD_MAX = MAX_MULT * CLK_DIV;
  localparam int BAUD_W   = $clog2(BAUD_MAX);
  localparam int BIT_W    = $clog2(DATA_W + 1);
  localparam int GAP_MULT = (GAP_BITS == 0) ? 1 : GAP_BITS;

  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLK_DIV - 1);
  localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(STOP_BITS * CLK_DIV - 1);
  localparam logic [BAUD_W-1:0] GAP_LAST  = BAUD_W'(GAP_MULT * CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(PACKET_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP
  } state_t;

  state_t              state_q,    state_d;
  logic [BAUD_W-1:0]   baud_q,     baud_d;
  logic [BIT_W-1:0]    bit_q,      bit_d;
  logic [DATA_W-1:0]   shift_q,    shift_d;
  logic                par_q,      par_d;
  logic                tx_q,       tx_d;
  logic [SEL_W-1:0]    select_q,   select_d;
  logic                pkt_done_q, pkt_done_d;
  logic                frame_end;

  // Next state and next outputs. By default the baud counter keeps counting
  // and every other flop holds its value. Each state restarts the baud
  // counter when it hands over to the next state. frame_end marks the last
  // cycle of the frame, and that is where the packet slot advances.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tx_d       = 1'b1;
    select_d   = select_q;
    pkt_done_d = 1'b0;
    frame_end  = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        // ready is high in IDLE, so valid alone completes the handshake.
        if (up.valid) begin
          shift_d = up.data;
          par_d   = (PARITY == 2) ? ~^up.data : ^up.data;
          state_d = S_START;
        end
      end

      S_START: begin
        tx_d = 1'b0;
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        tx_d = shift_q[0];
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      S_PARITY: begin
        tx_d = par_q;
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (baud_q == STOP_LAST) begin
          baud_d = '0;
          if (GAP_BITS != 0) begin
            state_d = S_GAP;
          end else begin
            state_d   = S_IDLE;
            frame_end = 1'b1;
          end
        end
      end

      S_GAP: begin
        if (baud_q == GAP_LAST) begin
          baud_d    = '0;
          state_d   = S_IDLE;
          frame_end = 1'b1;
        end
      end

      default: begin
        baud_d  = '0;
        bit_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // pkt_done is registered at the same edge that wraps select. It is
    // therefore visible in the first cycle with select == 0.
    if (frame_end) begin
      if (select_q == SEL_LAST) begin
        select_d   = '0;
        pkt_done_d = 1'b1;
      end else begin
        select_d = select_q + 1'b1;
      end
    end
  end

  // State and datapath registers. Reset aborts any frame in progress and
  // drives the line high at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      select_q   <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      select_q   <= select_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  assign up.ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign tx       = tx_q;
  assign select   = select_q;
  assign pkt_done = pkt_done_q;

endmodule

// File: tb/tb_uart_tx_packet_engine.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_packet_engine
//   Four engines with different parameter sets share one clock and reset:
//     0: CLK_DIV=4 DATA_W=8 no parity   STOP=1 GAP=1  (44-cycle frame)
//     1: CLK_DIV=4 DATA_W=8 even parity STOP=1 GAP=1  (48-cycle frame)
//     2: CLK_DIV=4 DATA_W=8 odd parity  STOP=1 GAP=1  (48-cycle frame)
//     3: CLK_DIV=3 DATA_W=7 no parity   STOP=2 GAP=0  (30-cycle frame)
//   A frame-level model works out, for each engine, the cycle offset into the
//   current frame. From that offset and the latched character it derives the
//   expected line level with plain arithmetic. Every output is compared on
//   every falling edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_packet_engine;

  localparam int N   = 4;
  localparam int PKT = 13;
  localparam int CFG_CD  [N] = '{4, 4, 4, 3};
  localparam int CFG_DW  [N] = '{8, 8, 8, 7};
  localparam int CFG_PAR [N] = '{0, 1, 2, 0};
  localparam int CFG_SB  [N] = '{1, 1, 1, 2};
  localparam int CFG_GB  [N] = '{1, 1, 1, 0};

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  logic [8:0] data_drv  [N];
  logic       valid_drv [N];
  logic       rdy_o     [N];
  logic       tx_o      [N];
  logic       busy_o    [N];
  logic       pd_o      [N];
  logic [3:0] sel_o     [N];

  int tests_run    = 0;
  int tests_failed = 0;

  // DUT instances, one per parameter set
  for (genvar g = 0; g < N; g++) begin : gen_dut
    uart_tx_packet_engine_if #(.DATA_W(CFG_DW[g])) bus ();

    assign bus.data  = data_drv[g][CFG_DW[g]-1:0];
    assign bus.valid = valid_drv[g];
    assign rdy_o[g]  = bus.ready;

    uart_tx_packet_engine #(
      .CLK_DIV    (CFG_CD[g]),
      .DATA_W     (CFG_DW[g]),
      .PARITY     (CFG_PAR[g]),
      .STOP_BITS  (CFG_SB[g]),
      .GAP_BITS   (CFG_GB[g]),
      .PACKET_LEN (PKT)
    ) dut (
      .clk      (clk),
      .reset    (reset),
      .up       (bus.slave),
      .select   (sel_o[g]),
      .tx       (tx_o[g]),
      .busy     (busy_o[g]),
      .pkt_done (pd_o[g])
    );
  end

  // Records one comparison and reports it if it fails
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Frame-level reference model
  function automatic int frameLen(input int i);
    return CFG_CD[i] * (1 + CFG_DW[i] + ((CFG_PAR[i] != 0) ? 1 : 0) + CFG_SB[i] + CFG_GB[i]);
  endfunction

  // Line level of bit period b of a frame that carries character d
  function automatic int frameBit(input int i, input int d, input int b);
    if (b == 0) return 0;
    if (b <= CFG_DW[i]) return (d >> (b - 1)) & 1;
    if (CFG_PAR[i] != 0 && b == CFG_DW[i] + 1)
      return (CFG_PAR[i] == 1) ? ($countones(d) & 1) : (1 - ($countones(d) & 1));
    return 1;
  endfunction

  bit m_active [N];
  int m_off    [N];
  int m_data   [N];
  int m_sel    [N];
  bit m_pd     [N];
  int m_done   [N];

  // m_off is the number of cycles since the handshake edge. A frame occupies
  // offsets 0..F-1, and at offset F the engine is idle again.
  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        m_active[i] <= 1'b0;
        m_off[i]    <= 0;
        m_sel[i]    <= 0;
        m_pd[i]     <= 1'b0;
        m_done[i]   <= 0;
      end else begin
        m_pd[i] <= 1'b0;
        if (m_active[i]) begin
          m_off[i] <= m_off[i] + 1;
          if (m_off[i] + 1 == frameLen(i)) begin
            m_active[i] <= 1'b0;
            m_done[i]   <= m_done[i] + 1;
            if (m_sel[i] == PKT - 1) begin
              m_sel[i] <= 0;
              m_pd[i]  <= 1'b1;
            end else begin
              m_sel[i] <= m_sel[i] + 1;
            end
          end
        end else if (valid_drv[i]) begin
          m_active[i] <= 1'b1;
          m_off[i]    <= 0;
          m_data[i]   <= int'(data_drv[i]) & ((1 << CFG_DW[i]) - 1);
        end
      end
    end
  end

  // Compare every output of every engine on each falling edge
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      int exp_tx;
      exp_tx = (m_active[i] && m_off[i] >= 1)
             ? frameBit(i, m_data[i], (m_off[i] - 1) / CFG_CD[i]) : 1;
      checkOutput($sformatf("tx[%0d]", i),       32'(tx_o[i]),   32'(exp_tx));
      checkOutput($sformatf("ready[%0d]", i),    32'(rdy_o[i]),  32'(!m_active[i]));
      checkOutput($sformatf("busy[%0d]", i),     32'(busy_o[i]), 32'(m_active[i]));
      checkOutput($sformatf("select[%0d]", i),   32'(sel_o[i]),  32'(m_sel[i]));
      checkOutput($sformatf("pkt_done[%0d]", i), 32'(pd_o[i]),   32'(m_pd[i]));
    end
  end

  // Capture buffers for the hand-computed waveform checks
  logic       cap_tx  [64];
  logic       cap_rdy [64];
  logic [3:0] cap_sel [64];

  // Sends character d on engine i, then records nCap falling-edge samples.
  // Sample k = 0 is the first falling edge after the handshake edge. If
  // raiseAt >= 0, valid is raised again with d2 at sample raiseAt and
  // dropped at the last sample.
  task automatic applyStimulus(input int i, input int d, input int nCap,
                               input int raiseAt, input int d2);
    int guard = 0;
    while (m_active[i] && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) checkOutput("wait_idle_timeout", 32'(guard), 32'd0);
    data_drv[i]  = 9'(d);
    valid_drv[i] = 1'b1;
    for (int k = 0; k < nCap; k++) begin
      @(negedge clk);
      cap_tx[k]  = tx_o[i];
      cap_rdy[k] = rdy_o[i];
      cap_sel[k] = sel_o[i];
      if (k == 0) valid_drv[i] = 1'b0;
      if (k == raiseAt) begin
        data_drv[i]  = 9'(d2);
        valid_drv[i] = 1'b1;
      end
      if (raiseAt >= 0 && k == nCap - 1) valid_drv[i] = 1'b0;
    end
  endtask

  // Compares the captured line against a written-out bit pattern, sampling
  // in the middle of each bit period
  task automatic checkPattern(input string name, input int cd, input string pat);
    for (int b = 0; b < pat.len(); b++) begin
      checkOutput($sformatf("%s_bit%0d", name, b),
                  32'(cap_tx[1 + cd * b + cd / 2]),
                  (pat[b] == "1") ? 32'd1 : 32'd0);
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int cnt;
    int pd_count;
    int frames;
    logic prev_busy;

    for (int i = 0; i < N; i++) begin
      valid_drv[i] = 1'b0;
      data_drv[i]  = '0;
    end
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset: line high, ready, slot 0, no pulses
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checkOutput("idle_tx",    32'(tx_o[0]),   32'd1);
      checkOutput("idle_ready", 32'(rdy_o[0]),  32'd1);
      checkOutput("idle_busy",  32'(busy_o[0]), 32'd0);
      checkOutput("idle_sel",   32'(sel_o[0]),  32'd0);
      checkOutput("idle_pd",    32'(pd_o[0]),   32'd0);
    end

    // 0xA5: one 44-cycle frame, ready again on cycle 45
    applyStimulus(0, 'hA5, 46, -1, 0);
    checkOutput("a5_tx_handshake_cycle", 32'(cap_tx[0]), 32'd1);
    checkOutput("a5_tx_first_low",       32'(cap_tx[1]), 32'd0);
    checkPattern("a5", 4, "01010010111");
    checkOutput("a5_ready_c44", 32'(cap_rdy[43]), 32'd0);
    checkOutput("a5_ready_c45", 32'(cap_rdy[44]), 32'd1);
    checkOutput("a5_select",    32'(cap_sel[44]), 32'd1);

    // Parity: even 0x07 gives 1, odd 0x07 gives 0, even 0x00 gives 0.
    // The frame is 48 cycles.
    applyStimulus(1, 'h07, 50, -1, 0);
    checkPattern("even07", 4, "011100000111");
    checkOutput("even07_ready_c48", 32'(cap_rdy[47]), 32'd0);
    checkOutput("even07_ready_c49", 32'(cap_rdy[48]), 32'd1);
    applyStimulus(2, 'h07, 50, -1, 0);
    checkPattern("odd07", 4, "011100000011");
    applyStimulus(1, 'h00, 50, -1, 0);
    checkPattern("even00", 4, "000000000011");

    // 7 data bits, 2 stop bits, no gap, CLK_DIV 3. A second valid raised
    // mid-frame waits for ready.
    applyStimulus(3, 'h55, 32, 10, 'h2A);
    checkPattern("d7_55", 3, "0101010111");
    checkOutput("d7_ready_midframe", 32'(cap_rdy[10]), 32'd0);
    checkOutput("d7_ready_c30",      32'(cap_rdy[29]), 32'd0);
    checkOutput("d7_ready_c31",      32'(cap_rdy[30]), 32'd1);
    checkOutput("d7_second_taken",   32'(cap_rdy[31]), 32'd0);

    // Reset in the middle of data bit 3 of 0x3C, then a clean 0x81 frame
    applyStimulus(0, 'h11, 46, -1, 0);
    applyStimulus(0, 'h3C, 19, -1, 0);
    checkOutput("abort_sel_before", 32'(sel_o[0]), 32'd2);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_tx",    32'(tx_o[0]),   32'd1);
    checkOutput("abort_sel",   32'(sel_o[0]),  32'd0);
    checkOutput("abort_ready", 32'(rdy_o[0]),  32'd1);
    checkOutput("abort_busy",  32'(busy_o[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 'h81, 46, -1, 0);
    checkPattern("x81", 4, "01000000111");
    checkOutput("x81_ready_c44", 32'(cap_rdy[43]), 32'd0);
    checkOutput("x81_ready_c45", 32'(cap_rdy[44]), 32'd1);

    // Valid held, data follows the slot: 13 back-to-back frames, one wrap
    pulseReset();
    cnt       = 0;
    pd_count  = 0;
    frames    = 0;
    prev_busy = busy_o[0];
    data_drv[0]  = '0;
    valid_drv[0] = 1'b1;
    while (cnt < 13 * 45 + 100) begin
      @(negedge clk);
      cnt++;
      if (pd_o[0]) pd_count++;
      if (prev_busy && !busy_o[0]) frames++;
      prev_busy   = busy_o[0];
      data_drv[0] = 9'(m_sel[0]);
      if (m_done[0] == 13) break;
    end
    valid_drv[0] = 1'b0;
    checkOutput("b2b_cycles", 32'(cnt),      32'd585);
    checkOutput("b2b_frames", 32'(frames),   32'd13);
    checkOutput("b2b_wrap",   32'(sel_o[0]), 32'd0);
    repeat (10) begin
      @(negedge clk);
      if (pd_o[0]) pd_count++;
    end
    checkOutput("b2b_pkt_done_count", 32'(pd_count), 32'd1);

    // Random traffic on all engines against the model
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        valid_drv[i] = ($urandom_range(0, 2) != 0);
        data_drv[i]  = 9'($urandom);
      end
    end
    for (int i = 0; i < N; i++) valid_drv[i] = 1'b0;
    repeat (60) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests_failed=%0d", tests_failed);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
